// File: rtl/seq_shiftadd_mult_pkg.sv
// Shared definitions for the RSA datapath arithmetic blocks.
//   state_t         : sequencer state encoding shared with the divider
//   RSA_WIDTH       : default operand width shared with the divider
//   cnt_width()     : width of an iteration counter that must hold WIDTH
package seq_shiftadd_mult_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int RSA_WIDTH = 1025;

  // Counter must represent the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_shiftadd_mult_cond_adder.sv
// Conditional adder for the shift-and-add multiplier.
//   a   : running partial-product high half (WIDTH bits)
//   b   : multiplicand (WIDTH bits)
//   en  : add b when high, pass a through when low
//   sum : WIDTH+1-bit result, carry kept in the top bit
// Kept as its own module so a carry-save or pipelined adder can replace it.
module sms_cond_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] w_addend;

  assign w_addend = en ? {1'b0, b} : '0;
  assign sum      = {1'b0, a} + w_addend;

endmodule

// File: rtl/seq_shiftadd_mult.sv
// Sequential radix-2 shift-and-add unsigned multiplier, one multiplier bit
// per clock. Constant latency of WIDTH+1 edges from accepted start to done.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : request a multiply, sampled only while idle
//   A, B       : multiplicand / multiplier, captured on the accepting edge
//   busy       : high while an operation is in progress
//   done       : one-cycle pulse, P valid from this cycle until next start
//   P          : 2*WIDTH-bit product, always driven as {hi, lo}
module seq_shiftadd_mult
  import seq_shiftadd_mult_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   w_sum;

  sms_cond_adder #(.WIDTH(WIDTH)) u_cond_adder (
    .a   (r_hi),
    .b   (r_mcand),
    .en  (r_lo[0]),
    .sum (w_sum)
  );

  // NOTE: every register, datapath included, is reset because P is an
  // architectural output that must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the values
      // from before this edge, independent of statement order.
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= A;
            r_lo    <= B;
            r_hi    <= '0;
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The full WIDTH+1-bit sum moves into hi and its LSB into lo, so
          // the carry lands in hi[WIDTH-1] and never overflows.
          {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
          r_cnt        <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign P    = {r_hi, r_lo};

endmodule

// File: tb/tb_seq_shiftadd_mult.sv
// Self-checking bench: an 8-bit instance with a per-cycle behavioural model
// plus a default-width (1025-bit) instance with directed and random runs.
module tb_seq_shiftadd_mult;

  localparam int W8 = 8;
  localparam int WW = 1025;
  localparam int PW = 2 * WW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          s8;
  logic [W8-1:0] a8, b8;
  logic          busy8, done8;
  logic [2*W8-1:0] p8;

  logic          sw;
  logic [WW-1:0] aw, bw;
  logic          busyw, donew;
  logic [PW-1:0] pw;

  seq_shiftadd_mult #(.WIDTH(W8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (s8),
    .A     (a8),
    .B     (b8),
    .busy  (busy8),
    .done  (done8),
    .P     (p8)
  );

  seq_shiftadd_mult u_dutw (
    .clk   (clk),
    .rst_n (rst_n),
    .start (sw),
    .A     (aw),
    .B     (bw),
    .busy  (busyw),
    .done  (donew),
    .P     (pw)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got hi=%h lo=%h want hi=%h lo=%h", name,
               act[PW-1:PW-64], act[63:0], exp[PW-1:PW-64], exp[63:0]);
    end
  endtask

  // Behavioural model of the 8-bit instance: an accepted start makes the
  // unit busy for W8 cycles, then done for one cycle with P = A*B.
  int            m_rem;
  logic          m_done;
  logic [2*W8-1:0] m_p;
  logic [W8-1:0] m_a, m_b;
  int            n_done8;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_p    = '0;
    end else if (m_rem == 0) begin
      m_done = 1'b0;
      if (s8) begin
        m_rem = W8;
        m_a   = a8;
        m_b   = b8;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_p    = (2*W8)'(m_a) * (2*W8)'(m_b);
      end
    end
  end

  initial n_done8 = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy8", PW'(busy8), PW'(m_rem != 0));
      check("done8", PW'(done8), PW'(m_done));
      check("busy_done_excl8", PW'(busy8 & done8), '0);
      if (m_rem == 0) check("p8_held", PW'(p8), PW'(m_p));
      if (done8) n_done8++;
    end
  end

  function automatic logic [WW-1:0] rand_w();
    logic [WW-1:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    r[WW-1] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // One 8-bit operation; returns edges from start to done (0 if timed out)
  // and the number of cycles busy was observed high.
  task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b,
                      output int lat, output int bcnt);
    @(negedge clk);
    a8 = a; b8 = b; s8 = 1'b1;
    @(posedge clk);
    lat = 0; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s8 = 1'b0;
      if (busy8) bcnt++;
      if (done8) begin lat = i + 1; break; end
    end
  endtask

  task automatic runw(input logic [WW-1:0] a, input logic [WW-1:0] b, input string name);
    int lat, bcnt, ovl;
    logic [PW-1:0] exp;
    exp = PW'(a) * PW'(b);
    @(negedge clk);
    aw = a; bw = b; sw = 1'b1;
    @(posedge clk);
    lat = 0; bcnt = 0; ovl = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      sw = 1'b0;
      aw = rand_w(); bw = rand_w();   // operands already captured
      if (busyw) bcnt++;
      if (busyw && donew) ovl++;
      if (donew) begin lat = i + 1; break; end
    end
    check({name, "_lat"}, PW'(lat), PW'(WW + 1));
    check({name, "_busy"}, PW'(bcnt), PW'(WW));
    check({name, "_excl"}, PW'(ovl), '0);
    check({name, "_p"}, pw, exp);
  endtask

  initial begin
    int lat, bcnt, nd0, t1, t2, nd, got;
    logic [W8-1:0] ra, rb;
    logic [PW-1:0] e_all;

    rst_n = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0; sw = 1'b0; aw = '0; bw = '0;
    #12;
    check("rst_busy8", PW'(busy8), '0);
    check("rst_done8", PW'(done8), '0);
    check("rst_p8", PW'(p8), '0);
    check("rst_pw", pw, '0);
    check("rst_busyw", PW'(busyw), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Smoke
    run8(8'd13, 8'd11, lat, bcnt);
    check("smoke_p", PW'(p8), PW'(16'd143));
    check("smoke_lat", PW'(lat), PW'(9));
    check("smoke_busy", PW'(bcnt), PW'(8));

    // Extremes
    run8(8'hFF, 8'hFF, lat, bcnt);
    check("ff_p", PW'(p8), PW'(16'hFE01));
    check("ff_lat", PW'(lat), PW'(9));
    run8(8'h00, 8'hFF, lat, bcnt);
    check("zero_p", PW'(p8), '0);
    check("zero_lat", PW'(lat), PW'(9));
    run8(8'd1, 8'd1, lat, bcnt);
    check("one_p", PW'(p8), PW'(16'd1));

    // Start pulses while busy are ignored; operand changes have no effect
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd7; s8 = 1'b1;
    @(posedge clk);
    nd0 = n_done8; lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s8 = (i == 2 || i == 4);
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (done8) begin
        lat = i + 1;
        check("hs_p", PW'(p8), PW'(16'd1400));
        break;
      end
    end
    s8 = 1'b0;
    repeat (3) @(posedge clk);
    check("hs_lat", PW'(lat), PW'(9));
    check("hs_single_done", PW'(n_done8 - nd0), PW'(1));

    // Back-to-back with start held high
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; s8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd199;
    nd = 0; t1 = -100; t2 = 0;
    for (int i = 1; i < 40; i++) begin
      if (i > 1) @(negedge clk);
      if (done8) begin
        if (nd == 0) begin
          t1 = i;
          check("b2b_p1", PW'(p8), PW'(16'd15));
        end else begin
          t2 = i;
          check("b2b_p2", PW'(p8), PW'(16'd39800));
          s8 = 1'b0;
        end
        nd++;
        if (nd == 2) break;
      end
    end
    s8 = 1'b0;
    check("b2b_count", PW'(nd), PW'(2));
    check("b2b_spacing", PW'(t2 - t1), PW'(9));

    // Reset in the middle of an operation
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; s8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_p", PW'(p8), '0);
    check("mid_rst_busy", PW'(busy8), '0);
    check("mid_rst_done", PW'(done8), '0);
    @(negedge clk);
    rst_n = 1'b1;
    nd0 = n_done8;
    repeat (12) @(posedge clk);
    check("mid_rst_no_done", PW'(n_done8 - nd0), '0);
    run8(8'd25, 8'd10, lat, bcnt);
    check("post_rst_p", PW'(p8), PW'(16'd250));
    check("post_rst_lat", PW'(lat), PW'(9));

    // Random 8-bit operands
    for (int k = 0; k < 200; k++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      run8(ra, rb, lat, bcnt);
      check("rnd8_p", PW'(p8), PW'(16'(ra) * 16'(rb)));
      check("rnd8_lat", PW'(lat), PW'(9));
    end

    // Default width: (2^1024+1)*(2^1024-1) = 2^2048-1
    e_all = (PW'(1) << 2048) - PW'(1);
    runw((WW'(1) << 1024) | WW'(1), (WW'(1) << 1024) - WW'(1), "wide_dir");
    check("wide_dir_lit", pw, e_all);

    for (int k = 0; k < 40; k++) runw(rand_w(), rand_w(), "wide_rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
